piece_move_ctrl: RTL



---
 rtl/piece_move_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/piece_move_ctrl.sv
// Active-piece movement controller: turns button edges and the gravity tick into
// grid moves/rotations, gated by the upstream move-permission flags.
module piece_move_ctrl #(
  parameter int GRID_W   = 10,
  parameter int GRID_H   = 20,
  parameter int X_W      = 4,
  parameter int Y_W      = 5,
  parameter int SPAWN_X  = 4,
  parameter int SPAWN_Y  = 0,
  parameter int GRAV_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_down,
  input  logic           btn_up,
  input  logic           left_en,
  input  logic           right_en,
  input  logic           down_en,
  input  logic           up_en,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     rot,
  output logic           moved,
  output logic           landed,
  output logic           game_over,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_SETTLE,
    S_ACTIVE,
    S_LOCK
  } state_e;

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;

  state_e           state_q;
  logic [X_W-1:0]   pos_x_q;
  logic [Y_W-1:0]   pos_y_q;
  logic [1:0]       rot_q;
  logic             moved_q;
  logic             landed_q;
  logic             game_over_q;
  logic             busy_q;
  logic [3:0]       btn_prev_q;
  logic [3:0]       pend_q;
  logic             grav_pend_q;
  logic [CNT_W-1:0] grav_cnt_q;

  logic [3:0] btn_now;
  logic [3:0] btn_rise;

  assign btn_now  = {btn_up, btn_down, btn_right, btn_left};
  assign btn_rise = btn_now & ~btn_prev_q;

  // NOTE: all state uses non-blocking assignments, so the later "set" statements
  // below override earlier "clear" statements within the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_x_q     <= X_W'(SPAWN_X);
      pos_y_q     <= Y_W'(SPAWN_Y);
      rot_q       <= 2'd0;
      moved_q     <= 1'b0;
      landed_q    <= 1'b0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
      btn_prev_q  <= 4'b0000;
      pend_q      <= 4'b0000;
      grav_pend_q <= 1'b0;
      grav_cnt_q  <= '0;
    end else begin
      moved_q    <= 1'b0;
      landed_q   <= 1'b0;
      btn_prev_q <= btn_now;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_SPAWN;
            game_over_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_SPAWN: begin
          pos_x_q     <= X_W'(SPAWN_X);
          pos_y_q     <= Y_W'(SPAWN_Y);
          rot_q       <= 2'd0;
          pend_q      <= 4'b0000;
          grav_pend_q <= 1'b0;
          grav_cnt_q  <= '0;
          state_q     <= S_SETTLE;
        end
        S_SETTLE: begin
          state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (grav_pend_q || pend_q[B_DOWN]) begin
            grav_pend_q    <= 1'b0;
            pend_q[B_DOWN] <= 1'b0;
            if (down_en && (pos_y_q < Y_W'(GRID_H - 1))) begin
              pos_y_q <= pos_y_q + 1'b1;
              moved_q <= 1'b1;
              state_q <= S_SETTLE;
            end else begin
              state_q <= S_LOCK;
            end
          end else if (pend_q[B_LEFT]) begin
            pend_q[B_LEFT] <= 1'b0;
            if (left_en && (pos_x_q != '0)) begin
              pos_x_q <= pos_x_q - 1'b1;
              moved_q <= 1'b1;
              state_q <= S_SETTLE;
            end
          end else if (pend_q[B_RIGHT]) begin
            pend_q[B_RIGHT] <= 1'b0;
            if (right_en && (pos_x_q < X_W'(GRID_W - 1))) begin
              pos_x_q <= pos_x_q + 1'b1;
              moved_q <= 1'b1;
              state_q <= S_SETTLE;
            end
          end else if (pend_q[B_UP]) begin
            pend_q[B_UP] <= 1'b0;
            if (up_en) begin
              rot_q   <= rot_q + 2'd1;
              moved_q <= 1'b1;
              state_q <= S_SETTLE;
            end
          end
        end
        S_LOCK: begin
          landed_q <= 1'b1;
          if (pos_y_q == Y_W'(SPAWN_Y)) begin
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_SPAWN;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // A button edge in the same cycle as its service re-arms the flag.
      for (int i = 0; i < 4; i++) begin
        if (btn_rise[i] && (state_q != S_IDLE)) pend_q[i] <= 1'b1;
      end

      if ((state_q == S_SETTLE) || (state_q == S_ACTIVE)) begin
        if (grav_cnt_q == CNT_W'(GRAV_DIV - 1)) begin
          grav_cnt_q  <= '0;
          grav_pend_q <= 1'b1;
        end else begin
          grav_cnt_q <= grav_cnt_q + 1'b1;
        end
      end
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign rot       = rot_q;
  assign moved     = moved_q;
  assign landed    = landed_q;
  assign game_over = game_over_q;
  assign busy      = busy_q;

endmodule
